// File: rtl/rv_hazard_pkg.sv
// Shared constants for the RV32 hazard scoreboard: RV32E defaults, the x0 index,
// and the width helper for counters that must hold 0..max inclusive.
package rv_hazard_pkg;
    localparam int RV32E_NUM_REGS = 16;
    localparam int RV32E_REG_AW   = 4;
    localparam int X0             = 0;

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/pend_scoreboard.sv
// Per-register pending bits for outstanding long-latency writes, the population
// count of those bits, and the sticky spurious-writeback error flag.
module pend_scoreboard
    import rv_hazard_pkg::*;
#(
    parameter int NUM_REGS = RV32E_NUM_REGS,
    parameter int REG_AW   = RV32E_REG_AW,
    parameter int PCW      = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                set_i,
    input  logic [REG_AW-1:0]   setidx_i,
    input  logic [NUM_REGS-1:0] clr_i,
    input  logic                wb_valid_i,
    output logic [NUM_REGS-1:0] eff_o,
    output logic                wb_hit_o,
    output logic [PCW-1:0]      pend_cnt_o,
    output logic                err_o
);
    logic [NUM_REGS-1:0] pending_d, pending_q, setmask;
    logic [PCW-1:0]      pend_cnt_d, pend_cnt_q;
    logic                err_d, err_q;

    assign eff_o    = pending_q & ~clr_i;
    assign wb_hit_o = |(pending_q & clr_i);

    always_comb begin
        setmask = '0;
        if (set_i) setmask[setidx_i] = 1'b1;
        pending_d     = eff_o | setmask;
        pending_d[X0] = 1'b0;
        pend_cnt_d    = pend_cnt_q + PCW'(set_i) - PCW'(wb_hit_o);
        // wb to x0 never produces a hit, so it is flagged here too
        err_d         = err_q | (wb_valid_i & ~wb_hit_o);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q  <= '0;
            pend_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
            err_q      <= err_d;
        end
    end

    assign pend_cnt_o = pend_cnt_q;
    assign err_o      = err_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: stalls on RAW/WAW against outstanding long writes or when
// the outstanding limit is hit. Optional stall counter enabled by HAZARD_PERF_EN.
module hazard_scoreboard
    import rv_hazard_pkg::*;
#(
    parameter int NUM_REGS = RV32E_NUM_REGS,
    parameter int REG_AW   = RV32E_REG_AW,
    parameter int MAX_PEND = 4,
    parameter int CNT_W    = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [REG_AW-1:0]          id_rs1_i,
    input  logic [REG_AW-1:0]          id_rs2_i,
    input  logic                       id_use_rs1_i,
    input  logic                       id_use_rs2_i,
    input  logic [REG_AW-1:0]          id_rd_i,
    input  logic                       id_wen_i,
    input  logic                       id_long_i,
    input  logic                       id_issue_i,
    input  logic                       flush_i,
    input  logic                       wb_valid_i,
    input  logic [REG_AW-1:0]          wb_rd_i,
    output logic                       stall_o,
    output logic [cnt_w(MAX_PEND)-1:0] pend_cnt_o,
    output logic                       err_o,
    output logic [CNT_W-1:0]           stall_cycles_o
);
    localparam int PCW = cnt_w(MAX_PEND);

    logic [NUM_REGS-1:0] clr, eff;
    logic                wb_hit, raw, waw, full, rd_nz, active, set;

    always_comb begin
        clr = '0;
        for (int r = 1; r < NUM_REGS; r++)
            if (wb_valid_i && wb_rd_i == REG_AW'(r)) clr[r] = 1'b1;
    end

    assign rd_nz  = (id_rd_i != REG_AW'(X0));
    assign active = id_issue_i && !flush_i;
    assign raw    = (id_use_rs1_i && id_rs1_i != REG_AW'(X0) && eff[id_rs1_i]) ||
                    (id_use_rs2_i && id_rs2_i != REG_AW'(X0) && eff[id_rs2_i]);
    assign waw    = id_wen_i && rd_nz && eff[id_rd_i];
    // a same-cycle writeback frees its slot for the issuing long op
    assign full   = id_long_i && id_wen_i && rd_nz &&
                    ((pend_cnt_o - PCW'(wb_hit)) == PCW'(MAX_PEND));
    assign stall_o = active && (raw || waw || full);
    assign set     = active && !stall_o && id_long_i && id_wen_i && rd_nz;

    pend_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW),
        .PCW      (PCW)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_i      (set),
        .setidx_i   (id_rd_i),
        .clr_i      (clr),
        .wb_valid_i (wb_valid_i),
        .eff_o      (eff),
        .wb_hit_o   (wb_hit),
        .pend_cnt_o (pend_cnt_o),
        .err_o      (err_o)
    );

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles_d, stall_cycles_q;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_o && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_cycles_q <= '0;
        else       stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles_o = stall_cycles_q;
`else
    assign stall_cycles_o = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench for hazard_scoreboard; a CNT_W=2 copy shares the inputs
// to exercise stall-counter saturation when HAZARD_PERF_EN is defined.
module tb_hazard_scoreboard;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] id_rs1_i, id_rs2_i, id_rd_i, wb_rd_i;
    logic       id_use_rs1_i, id_use_rs2_i, id_wen_i, id_long_i, id_issue_i, flush_i, wb_valid_i;
    logic       stall_o, err_o, stall2, err2;
    logic [2:0] pend_cnt_o, cnt2;
    logic [31:0] stall_cycles_o;
    logic [1:0]  sc2;

    int checks = 0;
    int failures = 0;
    int exp_sc = 0;

    always #5 clk_i = ~clk_i;

    hazard_scoreboard #(.NUM_REGS(16), .REG_AW(4), .MAX_PEND(4), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .id_rd_i(id_rd_i),
        .id_wen_i(id_wen_i), .id_long_i(id_long_i), .id_issue_i(id_issue_i),
        .flush_i(flush_i), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .stall_o(stall_o), .pend_cnt_o(pend_cnt_o), .err_o(err_o),
        .stall_cycles_o(stall_cycles_o)
    );

    hazard_scoreboard #(.NUM_REGS(16), .REG_AW(4), .MAX_PEND(4), .CNT_W(2)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .id_rd_i(id_rd_i),
        .id_wen_i(id_wen_i), .id_long_i(id_long_i), .id_issue_i(id_issue_i),
        .flush_i(flush_i), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .stall_o(stall2), .pend_cnt_o(cnt2), .err_o(err2),
        .stall_cycles_o(sc2)
    );

    typedef struct {
        logic [3:0] rs1, rs2, rd, wbrd;
        logic       u1, u2, wen, lng, iss, fl, wbv;
        logic       stall;
        logic [2:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [3:0] rs1, input logic u1, input logic [3:0] rs2,
                               input logic u2, input logic [3:0] rd, input logic wen,
                               input logic lng, input logic iss, input logic fl,
                               input logic wbv, input logic [3:0] wbrd,
                               input logic stall, input logic [2:0] cnt, input logic err);
        vec_t t;
        t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.wen = wen;
        t.lng = lng; t.iss = iss; t.fl = fl; t.wbv = wbv; t.wbrd = wbrd;
        t.stall = stall; t.cnt = cnt; t.err = err;
        return t;
    endfunction

    // shorthands: long load to rd, idle with optional writeback
    function automatic vec_t ld(input logic [3:0] rd, input logic wbv, input logic [3:0] wbrd,
                                input logic stall, input logic [2:0] cnt);
        return v(0, 0, 0, 0, rd, 1, 1, 1, 0, wbv, wbrd, stall, cnt, 0);
    endfunction

    function automatic vec_t idle(input logic wbv, input logic [3:0] wbrd,
                                  input logic [2:0] cnt, input logic err);
        return v(0, 0, 0, 0, 0, 0, 0, 0, 0, wbv, wbrd, 0, cnt, err);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_rs1_i = t.rs1; id_use_rs1_i = t.u1; id_rs2_i = t.rs2; id_use_rs2_i = t.u2;
        id_rd_i = t.rd; id_wen_i = t.wen; id_long_i = t.lng; id_issue_i = t.iss;
        flush_i = t.fl; wb_valid_i = t.wbv; wb_rd_i = t.wbrd;
    endtask

    task automatic check_sc(input string nm);
`ifdef HAZARD_PERF_EN
        check({nm, "_sc"}, stall_cycles_o, 32'(exp_sc));
        check({nm, "_sc2"}, 32'(sc2), (exp_sc > 3) ? 32'd3 : 32'(exp_sc));
`else
        check({nm, "_sc"}, stall_cycles_o, 32'd0);
        check({nm, "_sc2"}, 32'(sc2), 32'd0);
`endif
    endtask

    initial begin
        // load x5 then dependent add; WB arrives on the 4th ID cycle
        vecs.push_back(ld(5, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(v(5, 1, 0, 0, 10, 1, 0, 1, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(5, 1, 0, 0, 10, 1, 0, 1, 0, 1, 5, 0, 1, 0));
        vecs.push_back(idle(0, 0, 0, 0));
        // load x0 and a consumer of x0
        vecs.push_back(ld(0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 11, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(idle(0, 0, 0, 0));
        // fill to MAX_PEND, fifth load stalls, flush wins, WB x1 frees a slot
        vecs.push_back(ld(1, 0, 0, 0, 0));
        vecs.push_back(ld(2, 0, 0, 0, 1));
        vecs.push_back(ld(3, 0, 0, 0, 2));
        vecs.push_back(ld(4, 0, 0, 0, 3));
        vecs.push_back(ld(6, 0, 0, 1, 4));
        vecs.push_back(ld(6, 0, 0, 1, 4));
        vecs.push_back(v(0, 0, 0, 0, 6, 1, 1, 1, 1, 0, 0, 0, 4, 0));
        vecs.push_back(ld(6, 1, 1, 0, 4));
        vecs.push_back(idle(1, 2, 4, 0));
        vecs.push_back(idle(1, 3, 3, 0));
        vecs.push_back(idle(1, 4, 2, 0));
        vecs.push_back(idle(1, 6, 1, 0));
        vecs.push_back(idle(0, 0, 0, 0));
        // WAW on x7 (long and short), rs2 RAW, use flag gating, WB+reissue x7
        vecs.push_back(ld(7, 0, 0, 0, 0));
        vecs.push_back(ld(7, 0, 0, 1, 1));
        vecs.push_back(v(0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 0, 7, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
        vecs.push_back(v(0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(ld(7, 1, 7, 0, 1));
        vecs.push_back(idle(0, 0, 1, 0));
        vecs.push_back(idle(1, 7, 1, 0));
        vecs.push_back(idle(0, 0, 0, 0));
        // spurious writebacks: sticky error, count untouched
        vecs.push_back(idle(1, 9, 0, 0));
        vecs.push_back(idle(0, 0, 0, 1));
        vecs.push_back(idle(1, 0, 0, 1));
        vecs.push_back(idle(0, 0, 0, 1));

        drive(idle(0, 0, 0, 0));
        rst_i = 1'b1;
        #2;
        check("rst_stall", 32'(stall_o), 0);
        check("rst_cnt", 32'(pend_cnt_o), 0);
        check("rst_err", 32'(err_o), 0);
        check_sc("rst");
        @(negedge clk_i);
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk_i);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_stall", i), 32'(stall_o), 32'(vecs[i].stall));
            check($sformatf("v%0d_cnt", i), 32'(pend_cnt_o), 32'(vecs[i].cnt));
            check($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].err));
            check($sformatf("v%0d_stall2", i), 32'(stall2), 32'(vecs[i].stall));
            check($sformatf("v%0d_cnt2", i), 32'(cnt2), 32'(vecs[i].cnt));
            check_sc($sformatf("v%0d", i));
            @(posedge clk_i);
            if (vecs[i].stall) exp_sc++;
        end

        // reset asserted mid-stall clears everything without waiting for a clock
        @(negedge clk_i);
        drive(ld(5, 0, 0, 0, 0));
        @(negedge clk_i);
        drive(v(5, 1, 0, 0, 10, 1, 0, 1, 0, 0, 0, 1, 1, 0));
        #1;
        check("mid_stall", 32'(stall_o), 1);
        check("mid_cnt", 32'(pend_cnt_o), 1);
        rst_i = 1'b1;
        exp_sc = 0;
        #1;
        check("arst_stall", 32'(stall_o), 0);
        check("arst_cnt", 32'(pend_cnt_o), 0);
        check("arst_err", 32'(err_o), 0);
        check_sc("arst");
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(idle(0, 0, 0, 0));
        #1;
        check("post_rst_cnt", 32'(pend_cnt_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
